// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles, start/busy/done handshake.
// Optional subtract mode with signed-overflow flag is enabled by defining SERIAL_ADDER_CTRL_SUB_EN.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             fa_s;
    logic             fa_co;
    logic             last;
    logic             accept;

    full_adder u_fa (
        .x  (op_a[0]),
        .y  (op_b[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            op_a <= a;
            acc  <= '0;
            cnt  <= '0;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
            // Subtract as a + ~b + 1; cin is ignored in that mode.
            op_b    <= sub ? ~b : b;
            carry_q <= sub | cin;
`else
            op_b    <= b;
            carry_q <= cin;
`endif
        end else if (state == RUN) begin
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            carry_q <= fa_co;
            acc     <= {fa_s, acc[WIDTH-1:1]};
            cnt     <= cnt + CW'(1);
            if (last) begin
                sum  <= {fa_s, acc[WIDTH-1:1]};
                cout <= fa_co;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
                // carry_q here is the carry into the MSB.
                ovf  <= carry_q ^ fa_co;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=16.
module tb_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    logic        sub = 1'b0;
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_CTRL_SUB_EN
        ,
        .sub   (sub),
        .ovf   (ovf)
`endif
    );

    // Drive a request at a falling edge so it is accepted at the next rising edge.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h want=0000", sum); end
        n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_basic;
        int bad_busy, bad_done;
        bad_busy = 0; bad_done = 0;
        start_op(16'h0001, 16'h0001, 1'b0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (busy !== (i < 16)) bad_busy++;
            if (done !== (i == 16)) bad_done++;
            if (i == 16) begin
                n_tests++; if (sum !== 16'h0002) begin n_fail++; $display("FAIL basic_sum got=%h want=0002", sum); end
                n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b want=0", cout); end
            end
        end
        n_tests++; if (bad_busy != 0) begin n_fail++; $display("FAIL basic_busy_timing bad_cycles=%0d want=0", bad_busy); end
        n_tests++; if (bad_done != 0) begin n_fail++; $display("FAIL basic_done_timing bad_cycles=%0d want=0", bad_done); end
    endtask

    task automatic test_carry_out;
        bit ok;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL carry_done_timeout got=0 want=1"); end
        n_tests++; if (sum !== 16'h0000 || cout !== 1'b1) begin n_fail++; $display("FAIL carry_result got=%b_%h want=1_0000", cout, sum); end
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        start_op(16'h1234, 16'h4321, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sum !== 16'h0000 || cout !== 1'b1) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_prev_result bad_cycles=%0d want=0", bad); end
        @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b want=1", done); end
        n_tests++; if (sum !== 16'h5556 || cout !== 1'b0) begin n_fail++; $display("FAIL hold_result got=%b_%h want=0_5556", cout, sum); end
    endtask

    task automatic test_ignore_start;
        bit ok;
        int extra;
        extra = 0;
        start_op(16'h00FF, 16'h0001, 1'b0);
        repeat (4) @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ignore_done_timeout got=0 want=1"); end
        n_tests++; if (sum !== 16'h0100 || cout !== 1'b0) begin n_fail++; $display("FAIL ignore_result got=%b_%h want=0_0100", cout, sum); end
        // A start pulse during DONE must also be dropped.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL ignore_no_second_op active_cycles=%0d want=0", extra); end
        n_tests++; if (sum !== 16'h0100) begin n_fail++; $display("FAIL ignore_sum_stable got=%h want=0100", sum); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        start_op(16'h0002, 16'h0003, 1'b0);
        wait_done(ok);
        n_tests++; if (!ok || sum !== 16'h0005) begin n_fail++; $display("FAIL b2b_first got=%h ok=%b want=0005 ok=1", sum, ok); end
        a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap busy=%b done=%b want 0 0", busy, done); end
        @(posedge clk);
        #1 start = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy=%b want=1", busy); end
        wait_done(ok);
        n_tests++; if (!ok || sum !== 16'h0030 || cout !== 1'b0) begin n_fail++; $display("FAIL b2b_second got=%b_%h ok=%b want=0_0030 ok=1", cout, sum, ok); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int pulses;
        pulses = 0;
        start_op(16'h7FFF, 16'h7FFF, 1'b0);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl busy=%b done=%b want 0 0", busy, done); end
        n_tests++; if (sum !== 16'h0000 || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_result got=%b_%h want=0_0000", cout, sum); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_done active_cycles=%0d want=0", pulses); end
        start_op(16'h0003, 16'h0004, 1'b0);
        wait_done(ok);
        n_tests++; if (!ok || sum !== 16'h0007 || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_recover got=%b_%h ok=%b want=0_0007 ok=1", cout, sum, ok); end
    endtask

`ifdef SERIAL_ADDER_CTRL_SUB_EN
    task automatic test_sub;
        bit ok;
        sub = 1'b1;
        start_op(16'h0005, 16'h0007, 1'b0);
        wait_done(ok);
        n_tests++; if (!ok || sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL sub_5_7 got=%b_%h ovf=%b want=0_fffe ovf=0", cout, sum, ovf); end
        start_op(16'h8000, 16'h0001, 1'b0);
        wait_done(ok);
        n_tests++; if (!ok || sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL sub_8000_1 got=%b_%h ovf=%b want=1_7fff ovf=1", cout, sum, ovf); end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_out();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_ADDER_CTRL_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: reuses one FullAdder instance across all bits of a WIDTH-bit operand pair.
- Sequences the bits LSB first, one bit per clock, and holds the carry in a flip-flop between bits.
- Sits beside the parallel Add16 path as an area-minimal arithmetic resource.
- Exposes a start/busy/done handshake to the sequencing logic above it.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- cin  in  1  carry-in; captured on the accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: sum/cout just became valid.
- sum  out  WIDTH  last completed result; held until the next completion.
- cout  out  1  final carry of the last completed operation.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal operand shift registers, bit counter and carry flip-flop are also 0.
- Datapath: exactly one FullAdder instance. Its inputs are op_a[0], op_b[0] and carry_q. Operand registers shift right one bit per RUN cycle. Result bits shift into a WIDTH-bit accumulator from the MSB side, so after WIDTH shifts bit i sits at position i.
- IDLE:
  - If start=1 at an edge: latch a, b, cin (into carry_q); clear counter and accumulator; go to RUN.
  - If start=0: stay in IDLE.
- RUN:
  - Each edge: accumulator takes the FullAdder sum bit; carry_q takes the FullAdder carry; operands shift; counter increments.
  - On the edge where counter==WIDTH-1: copy the completed accumulator (including the final bit) to sum, copy the final carry to cout, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally. A start seen during DONE is ignored.
- Latency:
  - start accepted at edge N.
  - busy=1 from after edge N through edge N+WIDTH.
  - done=1 in the cycle after edge N+WIDTH.
  - Earliest next accept is edge N+WIDTH+2, giving throughput of one operation per WIDTH+2 cycles.
- start while busy or in DONE: ignored. No queuing; operand inputs are don't-care.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag in the base build.
- sum/cout change only on the completion edge. They stay stable through IDLE, RUN and DONE of the next operation until its completion edge.
- Reset mid-operation: immediate return to IDLE with all reset values. The partial result is discarded, and done must not pulse.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: SERIAL_ADDER_CTRL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with start.
  - sub=1 latches ~b and forces carry_q=1, ignoring cin, giving sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
  - Adds output ovf (1 bit), reset 0, updated at the completion edge. ovf=1 on signed two's-complement overflow, computed as the carry into the MSB XOR the carry out of the MSB.
  - sub=0 behaves exactly as the base build, and ovf is still computed.
- Not defined: no sub or ovf ports; add only.

Test Plan:
- WIDTH=16, a=0x0001, b=0x0001, cin=0, start pulsed at edge N:
  - busy high for 16 cycles.
  - done pulses in the cycle after edge N+16 with sum=0x0002, cout=0.
  - done is low on every other cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Check that the previous sum (0x0000) is held throughout RUN.
- Start 0x00FF+0x0001, then pulse start at cycle 5 with a=0xAAAA, b=0x5555:
  - Second request ignored; result sum=0x0100, cout=0.
  - No second done follows.
- Start 0x7FFF+0x7FFF, assert reset at cycle 7 of RUN:
  - busy=0, done=0, sum=0, cout=0 immediately, with no clock edge needed.
  - After reset release, 0x0003+0x0004 gives 0x0007.
- With SERIAL_ADDER_CTRL_SUB_EN:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
